mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 69 ++++++
 rtl/mc_decode.sv | 34 +++
 rtl/mc_ctrl.sv | 142 ++++++++++++++
 tb/tb_mc_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: state codes,
// opcode/function constants, datapath select encodings and the one-hot
// instruction class produced by mc_decode.
package mc_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNC_W  = 6;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [FUNC_W-1:0] FUNC_ADDU = 6'b100001;
  localparam logic [FUNC_W-1:0] FUNC_SUBU = 6'b100011;
  localparam logic [FUNC_W-1:0] FUNC_JR   = 6'b001000;

  // Next-PC source
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JAL = 2'b10;
  localparam logic [1:0] NPC_REG = 2'b11;

  // ALU operation
  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_LUI  = 3'b011;

  // Register-file write address select
  localparam logic [1:0] A3_RD = 2'b00;
  localparam logic [1:0] A3_RT = 2'b01;
  localparam logic [1:0] A3_RA = 2'b10;

  // Register-file write data select
  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_DM  = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  // One-hot instruction class
  typedef struct packed {
    logic illegal;
    logic jal;
    logic lui;
    logic beq;
    logic sw;
    logic lw;
    logic ori;
    logic jr;
    logic subu;
    logic addu;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
//   op        : IR[31:26]
//   func      : IR[5:0]
//   iclass_c  : one-hot class; anything unsupported lands in .illegal
module mc_decode
  import mc_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  output iclass_t           iclass_c
);

  always_comb begin
    iclass_c = '0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FUNC_ADDU: iclass_c.addu    = 1'b1;
          FUNC_SUBU: iclass_c.subu    = 1'b1;
          FUNC_JR:   iclass_c.jr      = 1'b1;
          default:   iclass_c.illegal = 1'b1;
        endcase
      end
      OP_ORI:  iclass_c.ori     = 1'b1;
      OP_LW:   iclass_c.lw      = 1'b1;
      OP_SW:   iclass_c.sw      = 1'b1;
      OP_BEQ:  iclass_c.beq     = 1'b1;
      OP_LUI:  iclass_c.lui     = 1'b1;
      OP_JAL:  iclass_c.jal     = 1'b1;
      default: iclass_c.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller for the MIPS subset addu/subu/jr/ori/lw/sw/beq/lui/jal.
// Only the state is registered; every control output is decoded
// combinationally from the state, the instruction fields, zero and mem_ready.
//   clk, reset          : clock, async active-high reset (forces FETCH)
//   op, func, zero      : instruction fields and ALU equal flag
//   mem_ready           : data memory completes this cycle
//   IRWrite .. MALUB    : datapath strobes and selects
//   state               : current state (debug)
//   retire              : one-cycle pulse at instruction completion
module mc_ctrl
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNC_W-1:0]  func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         NPCOp,
  output logic [2:0]         ALUCtrl,
  output logic               EXTOp,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         MGRFA3,
  output logic [1:0]         MGRFWD,
  output logic               MALUB,
  output logic [STATE_W-1:0] state,
  output logic               retire
);

  state_t  state_q, state_d;
  iclass_t iclass_c;

  mc_decode u_decode (
    .op       (op),
    .func     (func),
    .iclass_c (iclass_c)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and control decode
  always_comb begin
    state_d  = S_FETCH;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    NPCOp    = NPC_PC4;
    ALUCtrl  = ALU_NONE;
    EXTOp    = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MGRFA3   = A3_RD;
    MGRFWD   = WD_ALU;
    MALUB    = 1'b0;

    // ALU/EXT selects stay fixed from EXEC through WB so the ALU result is stable
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      if (iclass_c.addu)                  ALUCtrl = ALU_ADD;
      if (iclass_c.subu || iclass_c.beq)  ALUCtrl = ALU_SUB;
      if (iclass_c.ori)                   ALUCtrl = ALU_OR;
      if (iclass_c.lui)                   ALUCtrl = ALU_LUI;
      if (iclass_c.lw || iclass_c.sw)     ALUCtrl = ALU_ADD;
      MALUB = iclass_c.ori || iclass_c.lui || iclass_c.lw || iclass_c.sw;
      EXTOp = iclass_c.lw || iclass_c.sw;
    end

    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (iclass_c.jal) begin
          RegWrite = 1'b1;
          MGRFA3   = A3_RA;
          MGRFWD   = WD_PC4;
          PCWrite  = 1'b1;
          NPCOp    = NPC_JAL;
        end else if (iclass_c.jr) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_REG;
        end else if (iclass_c.illegal) begin
          PCWrite = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (iclass_c.beq) begin
          PCWrite = 1'b1;
          NPCOp   = zero ? NPC_BR : NPC_PC4;
        end else if (iclass_c.lw || iclass_c.sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        MemRead  = iclass_c.lw;
        MemWrite = iclass_c.sw;
        if (!mem_ready)        state_d = S_MEM;
        else if (iclass_c.sw)  PCWrite = 1'b1;
        else                   state_d = S_WB;
      end
      S_WB: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
        MGRFA3   = (iclass_c.addu || iclass_c.subu) ? A3_RD : A3_RT;
        MGRFWD   = iclass_c.lw ? WD_DM : WD_ALU;
      end
      default: ;
    endcase

    // The state register clears asynchronously, but FETCH would still raise
    // IRWrite, so every output is squashed while reset is held.
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      NPCOp    = NPC_PC4;
      ALUCtrl  = ALU_NONE;
      EXTOp    = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MGRFA3   = A3_RD;
      MGRFWD   = WD_ALU;
      MALUB    = 1'b0;
    end
  end

  assign state  = STATE_W'(state_q);
  assign retire = PCWrite;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed instruction table, reset corner sequences and
// random instruction streams checked against an instruction-level model.
module tb_mc_ctrl;

  localparam int MAX_CYC = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       IRWrite, PCWrite, EXTOp, RegWrite, MemRead, MemWrite, MALUB, retire;
  logic [1:0] NPCOp, MGRFA3, MGRFWD;
  logic [2:0] ALUCtrl, state;
  logic [19:0] all_outs;

  int checks   = 0;
  int failures = 0;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCOp(NPCOp), .ALUCtrl(ALUCtrl), .EXTOp(EXTOp),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MGRFA3(MGRFA3),
    .MGRFWD(MGRFWD), .MALUB(MALUB), .state(state), .retire(retire)
  );

  always #5 clk = ~clk;

  assign all_outs = {IRWrite, PCWrite, NPCOp, ALUCtrl, EXTOp, RegWrite, MemRead, MemWrite,
                     MGRFA3, MGRFWD, MALUB, state, retire};

  // Per-instruction observation summary (a3/wd/alu fields are -1 when unseen)
  typedef struct {
    int cyc; int states; int pcw; int npc; int regw; int a3; int wd;
    int memr; int memw; int irw; int irw_first; int alu; int malub; int ext;
    int hold_bad; int retire_bad; int timeout;
  } obs_t;

  typedef struct {
    string name; logic [5:0] op; logic [5:0] func; logic zero; int waits;
    int cyc; int npc; int regw; int a3; int wd; int memr; int memw;
    int alu; int malub; int ext;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t blank();
    obs_t o;
    o = '{default: 0};
    o.npc = -1; o.a3 = -1; o.wd = -1; o.alu = -1; o.malub = -1; o.ext = -1;
    return o;
  endfunction

  // Instruction-level reference: state path, strobe counts and selects
  function automatic obs_t model(input logic [5:0] op_i, input logic [5:0] func_i,
                                 input logic zero_i, input int waits);
    obs_t e;
    int   st[$];
    bit   r    = (op_i == 6'b000000);
    bit   addu = r && func_i == 6'b100001;
    bit   subu = r && func_i == 6'b100011;
    bit   jr   = r && func_i == 6'b001000;
    bit   ori  = op_i == 6'b001101;
    bit   lui  = op_i == 6'b001111;
    bit   lw   = op_i == 6'b100011;
    bit   sw   = op_i == 6'b101011;
    bit   beq  = op_i == 6'b000100;
    bit   jal  = op_i == 6'b000011;
    e = blank();
    e.pcw = 1; e.irw = 1; e.irw_first = 1; e.npc = 0;
    st.push_back(0); st.push_back(1);
    if (jal) begin
      e.npc = 2; e.regw = 1; e.a3 = 2; e.wd = 2;
    end else if (jr) begin
      e.npc = 3;
    end else if (beq) begin
      st.push_back(2);
      e.npc = zero_i ? 1 : 0; e.alu = 6; e.malub = 0; e.ext = 0;
    end else if (addu || subu || ori || lui) begin
      st.push_back(2); st.push_back(4);
      e.regw = 1; e.a3 = (addu || subu) ? 0 : 1; e.wd = 0;
      e.alu = addu ? 2 : subu ? 6 : ori ? 1 : 3;
      e.malub = (ori || lui) ? 1 : 0; e.ext = 0;
    end else if (lw || sw) begin
      st.push_back(2);
      repeat (waits + 1) st.push_back(3);
      e.alu = 2; e.malub = 1; e.ext = 1;
      if (lw) begin
        st.push_back(4);
        e.regw = 1; e.a3 = 1; e.wd = 1; e.memr = waits + 1;
      end else begin
        e.memw = waits + 1;
      end
    end
    e.cyc = st.size();
    foreach (st[i]) e.states = (e.states << 3) | st[i];
    return e;
  endfunction

  // Runs one instruction from FETCH until PCWrite (entered just after a rising edge)
  task automatic run_instr(input logic [5:0] op_i, input logic [5:0] func_i,
                           input logic zero_i, input int waits, output obs_t o);
    int c;
    bit done;
    o = blank();
    c = 0;
    done = 0;
    while (!done) begin
      if (c >= MAX_CYC) begin
        o.timeout = 1;
        break;
      end
      op = op_i; func = func_i;
      zero = (c == 2) ? zero_i : 1'($urandom);
      mem_ready = (c >= 3 + waits) ? 1'b1 : ((c < 3) ? 1'($urandom) : 1'b0);
      #1;
      o.states = (o.states << 3) | int'(state);
      if (IRWrite) begin o.irw++; if (c == 0) o.irw_first = 1; end
      if (PCWrite) begin o.pcw++; o.npc = int'(NPCOp); done = 1; end
      if (RegWrite) begin o.regw++; o.a3 = int'(MGRFA3); o.wd = int'(MGRFWD); end
      if (MemRead)  o.memr++;
      if (MemWrite) o.memw++;
      if (retire !== PCWrite) o.retire_bad++;
      if (state == 3'd2) begin
        o.alu = int'(ALUCtrl); o.malub = int'(MALUB); o.ext = int'(EXTOp);
      end else if (state == 3'd3 || state == 3'd4) begin
        if (int'(ALUCtrl) != o.alu || int'(MALUB) != o.malub || int'(EXTOp) != o.ext)
          o.hold_bad++;
      end
      c++;
      @(posedge clk); #2;
    end
    o.cyc = c;
  endtask

  task automatic cmp(input string tag, input obs_t o, input obs_t e);
    chk({tag, " timeout"},    o.timeout,    e.timeout);
    chk({tag, " cycles"},     o.cyc,        e.cyc);
    chk({tag, " states"},     o.states,     e.states);
    chk({tag, " pcwrite"},    o.pcw,        e.pcw);
    chk({tag, " npcop"},      o.npc,        e.npc);
    chk({tag, " regwrite"},   o.regw,       e.regw);
    chk({tag, " mgrfa3"},     o.a3,         e.a3);
    chk({tag, " mgrfwd"},     o.wd,         e.wd);
    chk({tag, " memread"},    o.memr,       e.memr);
    chk({tag, " memwrite"},   o.memw,       e.memw);
    chk({tag, " irwrite"},    o.irw,        e.irw);
    chk({tag, " irw_first"},  o.irw_first,  e.irw_first);
    chk({tag, " aluctrl"},    o.alu,        e.alu);
    chk({tag, " malub"},      o.malub,      e.malub);
    chk({tag, " extop"},      o.ext,        e.ext);
    chk({tag, " alu_hold"},   o.hold_bad,   e.hold_bad);
    chk({tag, " retire"},     o.retire_bad, e.retire_bad);
  endtask

  function automatic vec_t mk(input string n, input logic [5:0] o, input logic [5:0] f,
                              input logic z, input int w, input int cyc, input int npc,
                              input int regw, input int a3, input int wd, input int memr,
                              input int memw, input int alu, input int malub, input int ext);
    vec_t v;
    v.name = n; v.op = o; v.func = f; v.zero = z; v.waits = w;
    v.cyc = cyc; v.npc = npc; v.regw = regw; v.a3 = a3; v.wd = wd;
    v.memr = memr; v.memw = memw; v.alu = alu; v.malub = malub; v.ext = ext;
    return v;
  endfunction

  task automatic resync();
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
  endtask

  initial begin
    vec_t vecs[$];
    obs_t o, e;
    int   pcw_seen;

    // name, op, func, zero, waits | cycles, npc, regw, a3, wd, memr, memw, alu, malub, ext
    vecs.push_back(mk("addu",    6'b000000, 6'b100001, 0, 0, 4, 0, 1,  0,  0, 0, 0,  2,  0,  0));
    vecs.push_back(mk("subu",    6'b000000, 6'b100011, 1, 0, 4, 0, 1,  0,  0, 0, 0,  6,  0,  0));
    vecs.push_back(mk("ori",     6'b001101, 6'b000000, 0, 0, 4, 0, 1,  1,  0, 0, 0,  1,  1,  0));
    vecs.push_back(mk("lui",     6'b001111, 6'b101010, 0, 0, 4, 0, 1,  1,  0, 0, 0,  3,  1,  0));
    vecs.push_back(mk("lw_w3",   6'b100011, 6'b100001, 0, 3, 8, 0, 1,  1,  1, 4, 0,  2,  1,  1));
    vecs.push_back(mk("lw_w0",   6'b100011, 6'b000000, 0, 0, 5, 0, 1,  1,  1, 1, 0,  2,  1,  1));
    vecs.push_back(mk("sw_w2",   6'b101011, 6'b001000, 0, 2, 6, 0, 0, -1, -1, 0, 3,  2,  1,  1));
    vecs.push_back(mk("sw_w0",   6'b101011, 6'b000000, 0, 0, 4, 0, 0, -1, -1, 0, 1,  2,  1,  1));
    vecs.push_back(mk("beq_z1",  6'b000100, 6'b000000, 1, 0, 3, 1, 0, -1, -1, 0, 0,  6,  0,  0));
    vecs.push_back(mk("beq_z0",  6'b000100, 6'b000000, 0, 0, 3, 0, 0, -1, -1, 0, 0,  6,  0,  0));
    vecs.push_back(mk("jal",     6'b000011, 6'b000000, 0, 0, 2, 2, 1,  2,  2, 0, 0, -1, -1, -1));
    vecs.push_back(mk("jr",      6'b000000, 6'b001000, 0, 0, 2, 3, 0, -1, -1, 0, 0, -1, -1, -1));
    vecs.push_back(mk("nop_op",  6'b111111, 6'b000000, 0, 0, 2, 0, 0, -1, -1, 0, 0, -1, -1, -1));
    vecs.push_back(mk("nop_fn",  6'b000000, 6'b000000, 0, 0, 2, 0, 0, -1, -1, 0, 0, -1, -1, -1));

    // Outputs all zero while reset is held, whatever the inputs
    reset = 1'b1; op = '0; func = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (3) begin
      op = 6'b101011; func = 6'($urandom); zero = 1'($urandom); mem_ready = 1'($urandom);
      @(posedge clk); #3;
      chk("reset_outputs", int'(all_outs), 0);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("release_state",   int'(state),   0);
    chk("release_irwrite", int'(IRWrite), 1);

    // Directed table
    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].func, vecs[i].zero, vecs[i].waits, o);
      e = model(vecs[i].op, vecs[i].func, vecs[i].zero, vecs[i].waits);
      e.cyc = vecs[i].cyc; e.npc = vecs[i].npc; e.regw = vecs[i].regw;
      e.a3 = vecs[i].a3; e.wd = vecs[i].wd; e.memr = vecs[i].memr; e.memw = vecs[i].memw;
      e.alu = vecs[i].alu; e.malub = vecs[i].malub; e.ext = vecs[i].ext;
      cmp(vecs[i].name, o, e);
      if (o.timeout) resync();
    end

    // Reset asserted mid-cycle while sw waits in MEM
    op = 6'b101011; func = 6'($urandom); mem_ready = 1'b0; zero = 1'b0;
    repeat (3) begin #1; @(posedge clk); #2; end
    #1;
    chk("sw_wait_state",    int'(state),    3);
    chk("sw_wait_memwrite", int'(MemWrite), 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_state",    int'(state),    0);
    chk("rst_mid_memwrite", int'(MemWrite), 0);
    chk("rst_mid_outputs",  int'(all_outs), 0);
    pcw_seen = 0;
    repeat (2) begin
      mem_ready = 1'b1;
      @(posedge clk); #3;
      pcw_seen += int'(PCWrite);
    end
    chk("rst_no_pcwrite", pcw_seen, 0);
    reset = 1'b0;
    #1;
    chk("rst2_state",   int'(state),   0);
    chk("rst2_irwrite", int'(IRWrite), 1);

    // Random instruction stream against the model
    for (int n = 0; n < 200; n++) begin
      logic [5:0] rop, rfn;
      logic       rz;
      int         rw;
      rfn = 6'($urandom);
      case ($urandom_range(0, 9))
        0: begin rop = 6'b000000; rfn = 6'b100001; end
        1: begin rop = 6'b000000; rfn = 6'b100011; end
        2: begin rop = 6'b000000; rfn = 6'b001000; end
        3: rop = 6'b001101;
        4: rop = 6'b100011;
        5: rop = 6'b101011;
        6: rop = 6'b000100;
        7: rop = 6'b001111;
        8: rop = 6'b000011;
        default: rop = 6'($urandom);
      endcase
      rz = 1'($urandom);
      rw = $urandom_range(0, 5);
      run_instr(rop, rfn, rz, rw, o);
      e = model(rop, rfn, rz, rw);
      cmp($sformatf("rnd%0d op=%0h fn=%0h", n, rop, rfn), o, e);
      if (o.timeout) resync();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
